// File: rtl/keypad_scanner_if.sv
// Key handshake between the keypad scanner and the Wishbone register front end.
// The scanner presents a latched code; the consumer acknowledges it.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns on each scan tick,
// debounces a press on the sampled rows and latches its code for the consumer.
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [3:0]          row_in,
    output logic [3:0]          col_out,
    keypad_scanner_if.master    kif
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync_q, rows_s_q;
    logic [1:0]    c_q, c_d;
    logic [1:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overrun_q, overrun_d;
    logic          latch;
    logic [1:0]    low_idx;

    assign cnt_inc = cnt_q + CW'(1);

    // Lowest-numbered asserted (low) row wins when several are pressed.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s_q[i]) low_idx = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            sync_q      <= 4'hF;
            rows_s_q    <= 4'hF;
            c_q         <= 2'd0;
            r_q         <= 2'd0;
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= row_in;
            rows_s_q    <= sync_q;
            c_q         <= c_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rows_s_q == 4'hF) begin
                        c_d = c_q + 2'd1;
                    end else begin
                        r_d = low_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            latch   = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (rows_s_q[r_q]) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                        latch   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HOLD: begin
                    // Only the latched key's row matters; other keys are ignored.
                    if (!rows_s_q[r_q]) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                        cnt_d   = '0;
                        c_d     = c_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        col_d       = ~(4'b0001 << c_d);
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (kif.key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        // A same-cycle ack frees the slot, so the new key is taken instead of lost.
        if (latch) begin
            if (!key_valid_q || kif.key_ack) begin
                key_code_d  = {r_d, c_q};
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign col_out       = col_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.overrun   = overrun_q;
endmodule
